// File: rtl/inst_encoder_pkg.sv
// Encoder package: instruction formats, per-order field lookup and the optional
// operand range check used by inst_encoder.
`include "inst_defs.sv"

package inst_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_NONE, FMT_U, FMT_I, FMT_SH, FMT_R, FMT_S, FMT_B, FMT_J
  } fmt_e;

  typedef struct packed {
    fmt_e       fmt;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
  } order_info_t;

  // One FIFO entry: error flag above the encoded word.
  typedef struct packed {
    logic                   err;
    logic [`DATA_WIDTH-1:0] inst;
  } enc_word_t;

  localparam int ENC_W = $bits(enc_word_t);

  // Map an order code to its format, opcode, funct3 and funct7.
  function automatic order_info_t order_info(input logic [`INST_TYPE_WIDTH-1:0] t);
    order_info_t r;
    r = '{FMT_NONE, 7'h00, 3'd0, `F7_BASE};
    case (t)
      `LUI:   r = '{FMT_U,  `OPC_LUI,    3'd0, `F7_BASE};
      `AUIPC: r = '{FMT_U,  `OPC_AUIPC,  3'd0, `F7_BASE};
      `ADDI:  r = '{FMT_I,  `OPC_OPIMM,  3'd0, `F7_BASE};
      `SLTI:  r = '{FMT_I,  `OPC_OPIMM,  3'd2, `F7_BASE};
      `SLTIU: r = '{FMT_I,  `OPC_OPIMM,  3'd3, `F7_BASE};
      `XORI:  r = '{FMT_I,  `OPC_OPIMM,  3'd4, `F7_BASE};
      `ORI:   r = '{FMT_I,  `OPC_OPIMM,  3'd6, `F7_BASE};
      `ANDI:  r = '{FMT_I,  `OPC_OPIMM,  3'd7, `F7_BASE};
      `SLLI:  r = '{FMT_SH, `OPC_OPIMM,  3'd1, `F7_BASE};
      `SRLI:  r = '{FMT_SH, `OPC_OPIMM,  3'd5, `F7_BASE};
      `SRAI:  r = '{FMT_SH, `OPC_OPIMM,  3'd5, `F7_ALT};
      `ADD:   r = '{FMT_R,  `OPC_OP,     3'd0, `F7_BASE};
      `SUB:   r = '{FMT_R,  `OPC_OP,     3'd0, `F7_ALT};
      `SLL:   r = '{FMT_R,  `OPC_OP,     3'd1, `F7_BASE};
      `SLT:   r = '{FMT_R,  `OPC_OP,     3'd2, `F7_BASE};
      `SLTU:  r = '{FMT_R,  `OPC_OP,     3'd3, `F7_BASE};
      `XOR:   r = '{FMT_R,  `OPC_OP,     3'd4, `F7_BASE};
      `SRL:   r = '{FMT_R,  `OPC_OP,     3'd5, `F7_BASE};
      `SRA:   r = '{FMT_R,  `OPC_OP,     3'd5, `F7_ALT};
      `OR:    r = '{FMT_R,  `OPC_OP,     3'd6, `F7_BASE};
      `AND:   r = '{FMT_R,  `OPC_OP,     3'd7, `F7_BASE};
      `LB:    r = '{FMT_I,  `OPC_LOAD,   3'd0, `F7_BASE};
      `LH:    r = '{FMT_I,  `OPC_LOAD,   3'd1, `F7_BASE};
      `LW:    r = '{FMT_I,  `OPC_LOAD,   3'd2, `F7_BASE};
      `LBU:   r = '{FMT_I,  `OPC_LOAD,   3'd4, `F7_BASE};
      `LHU:   r = '{FMT_I,  `OPC_LOAD,   3'd5, `F7_BASE};
      `SB:    r = '{FMT_S,  `OPC_STORE,  3'd0, `F7_BASE};
      `SH:    r = '{FMT_S,  `OPC_STORE,  3'd1, `F7_BASE};
      `SW:    r = '{FMT_S,  `OPC_STORE,  3'd2, `F7_BASE};
      `JAL:   r = '{FMT_J,  `OPC_JAL,    3'd0, `F7_BASE};
      `JALR:  r = '{FMT_I,  `OPC_JALR,   3'd0, `F7_BASE};
      `BEQ:   r = '{FMT_B,  `OPC_BRANCH, 3'd0, `F7_BASE};
      `BNE:   r = '{FMT_B,  `OPC_BRANCH, 3'd1, `F7_BASE};
      `BLT:   r = '{FMT_B,  `OPC_BRANCH, 3'd4, `F7_BASE};
      `BGE:   r = '{FMT_B,  `OPC_BRANCH, 3'd5, `F7_BASE};
      `BLTU:  r = '{FMT_B,  `OPC_BRANCH, 3'd6, `F7_BASE};
      `BGEU:  r = '{FMT_B,  `OPC_BRANCH, 3'd7, `F7_BASE};
      default: ;
    endcase
    return r;
  endfunction

  // True when the immediate does not fit its field, or a used register index exceeds 31.
  function automatic logic range_bad(input fmt_e fmt, input logic [31:0] imm,
                                     input logic [31:0] rd, input logic [31:0] rs1,
                                     input logic [31:0] rs2);
    logic i_ok, b_ok, j_ok, rd_hi, rs1_hi, rs2_hi, bad;
    i_ok   = (&imm[31:11]) | ~(|imm[31:11]);
    b_ok   = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    j_ok   = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
    rd_hi  = |rd[31:5];
    rs1_hi = |rs1[31:5];
    rs2_hi = |rs2[31:5];
    bad    = 1'b0;
    case (fmt)
      FMT_U:   bad = (|imm[11:0]) | rd_hi;
      FMT_I:   bad = ~i_ok | rd_hi | rs1_hi;
      FMT_SH:  bad = (|imm[31:5]) | rd_hi | rs1_hi;
      FMT_R:   bad = rd_hi | rs1_hi | rs2_hi;
      FMT_S:   bad = ~i_ok | rs1_hi | rs2_hi;
      FMT_B:   bad = ~b_ok | rs1_hi | rs2_hi;
      FMT_J:   bad = ~j_ok | rd_hi;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/inst_defs.sv
// Shared instruction definitions: data/order-code widths, order codes (same codes the
// decoder emits), RV32I opcodes and funct7 constants. Safe to include more than once.
`ifndef INST_DEFS_SV
`define INST_DEFS_SV

`define DATA_WIDTH      32
`define INST_TYPE_WIDTH 6

`define LUI    6'd0
`define AUIPC  6'd1
`define ADDI   6'd2
`define SLTI   6'd3
`define SLTIU  6'd4
`define XORI   6'd5
`define ORI    6'd6
`define ANDI   6'd7
`define SLLI   6'd8
`define SRLI   6'd9
`define SRAI   6'd10
`define ADD    6'd11
`define SUB    6'd12
`define SLL    6'd13
`define SLT    6'd14
`define SLTU   6'd15
`define XOR    6'd16
`define SRL    6'd17
`define SRA    6'd18
`define OR     6'd19
`define AND    6'd20
`define LB     6'd21
`define LH     6'd22
`define LW     6'd23
`define LBU    6'd24
`define LHU    6'd25
`define SB     6'd26
`define SH     6'd27
`define SW     6'd28
`define JAL    6'd29
`define JALR   6'd30
`define BEQ    6'd31
`define BNE    6'd32
`define BLT    6'd33
`define BGE    6'd34
`define BLTU   6'd35
`define BGEU   6'd36

`define OPC_LUI    7'b0110111
`define OPC_AUIPC  7'b0010111
`define OPC_JAL    7'b1101111
`define OPC_JALR   7'b1100111
`define OPC_BRANCH 7'b1100011
`define OPC_LOAD   7'b0000011
`define OPC_STORE  7'b0100011
`define OPC_OPIMM  7'b0010011
`define OPC_OP     7'b0110011

`define F7_BASE 7'h00
`define F7_ALT  7'h20

`endif

// File: rtl/inst_enc_fifo.sv
// Two-entry synchronous FIFO with occupancy count. No bypass: the head is always
// a registered entry, and full depends only on the registered count.
module inst_enc_fifo #(
  parameter int W = 33
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         valid,
  output logic [W-1:0] head
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign full  = (count_q == 2'd2);
  assign valid = (count_q != 2'd0);
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and count from push/pop.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path infers a latch.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && valid;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the FIFO immediately.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      // NOTE: the storage is reset too, so the head reads all-zero straight out of reset.
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: packs a decoded order into a 32-bit RV32I instruction word, queued
// through a 2-entry output FIFO. Define INST_ENC_RANGE_CHECK_EN to flag immediates
// and register indices that do not fit their fields; otherwise they are truncated.
`include "inst_defs.sv"

module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [`INST_TYPE_WIDTH-1:0] order_type,
  input  logic [`DATA_WIDTH-1:0]      order_rd,
  input  logic [`DATA_WIDTH-1:0]      order_rs1,
  input  logic [`DATA_WIDTH-1:0]      order_rs2,
  input  logic [`DATA_WIDTH-1:0]      order_imm,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [`DATA_WIDTH-1:0]      out_inst,
  output logic                        out_err,
  output logic [ERR_CNT_W-1:0]        err_cnt
);

  order_info_t          info;
  enc_word_t            enc;
  enc_word_t            head;
  logic                 fifo_full;
  logic                 push;
  logic [4:0]           rd, rs1, rs2;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign rd   = order_rd[4:0];
  assign rs1  = order_rs1[4:0];
  assign rs2  = order_rs2[4:0];
  assign push = in_valid && in_ready;

`ifndef INST_ENC_RANGE_CHECK_EN
  // Upper index bits only matter to the range check.
  logic unused_reg_hi;
  assign unused_reg_hi = ^{order_rd[31:5], order_rs1[31:5], order_rs2[31:5]};
`endif

  // Encode the order; anything unencodable becomes {err=1, inst=0}.
  always_comb begin
    info = order_info(order_type);
    enc  = '0;
    case (info.fmt)
      FMT_U:   enc.inst = {order_imm[31:12], rd, info.opc};
      FMT_I:   enc.inst = {order_imm[11:0], rs1, info.f3, rd, info.opc};
      FMT_SH:  enc.inst = {info.f7, order_imm[4:0], rs1, info.f3, rd, info.opc};
      FMT_R:   enc.inst = {info.f7, rs2, rs1, info.f3, rd, info.opc};
      FMT_S:   enc.inst = {order_imm[11:5], rs2, rs1, info.f3, order_imm[4:0], info.opc};
      FMT_B:   enc.inst = {order_imm[12], order_imm[10:5], rs2, rs1, info.f3,
                           order_imm[4:1], order_imm[11], info.opc};
      FMT_J:   enc.inst = {order_imm[20], order_imm[10:1], order_imm[11],
                           order_imm[19:12], rd, info.opc};
      default: enc.err  = 1'b1;
    endcase
`ifdef INST_ENC_RANGE_CHECK_EN
    if (range_bad(info.fmt, order_imm, order_rd, order_rs1, order_rs2)) enc.err = 1'b1;
`endif
    if (enc.err) enc.inst = '0;
  end

  // Saturating count of accepted orders that carried an error.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && enc.err && !(&err_cnt_q)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  // Error counter register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) err_cnt_q <= '0;
    else         err_cnt_q <= err_cnt_d;
  end

  inst_enc_fifo #(.W(ENC_W)) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (push),
    .push_data (enc),
    .pop       (out_ready),
    .full      (fifo_full),
    .valid     (out_valid),
    .head      (head)
  );

  assign in_ready = !fifo_full;
  assign out_inst = head.inst;
  assign out_err  = head.err;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: table of orders with hand-derived encodings, a scoreboard
// queue filled at accept and drained by an output monitor, plus back-pressure,
// mid-cycle reset and error-counter saturation sequences.
`include "inst_defs.sv"

module tb_inst_encoder;

  localparam int ERR_CNT_W = 16;
  localparam int NV        = 17;
`ifdef INST_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic                        clk_in = 1'b0;
  logic                        rst_in = 1'b0;
  logic                        in_valid = 1'b0;
  logic                        in_ready;
  logic [`INST_TYPE_WIDTH-1:0] order_type = '0;
  logic [31:0]                 order_rd = '0, order_rs1 = '0, order_rs2 = '0, order_imm = '0;
  logic                        out_valid;
  logic                        out_ready = 1'b0;
  logic [31:0]                 out_inst;
  logic                        out_err;
  logic [ERR_CNT_W-1:0]        err_cnt;

  typedef struct {
    string       name;
    logic [5:0]  typ;
    logic [31:0] rd, rs1, rs2, imm;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic        err;
    logic [31:0] inst;
  } exp_t;

  vec_t                 vecs [NV];
  exp_t                 exp_q [$];
  exp_t                 mon_e;
  logic [ERR_CNT_W-1:0] exp_err_cnt = '0;
  int                   n_checks = 0;
  int                   n_fail = 0;

  inst_encoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .order_type (order_type),
    .order_rd   (order_rd),
    .order_rs1  (order_rs1),
    .order_rs2  (order_rs2),
    .order_imm  (order_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_err    (out_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: a pop happens at the next rising edge when valid && ready here.
  always @(negedge clk_in) begin
    if (rst_in && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {31'd0, out_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_inst", out_inst, mon_e.inst);
        check("out_err", {31'd0, out_err}, {31'd0, mon_e.err});
      end
    end
  end

  task automatic drive_vec(input int i);
    order_type = vecs[i].typ;
    order_rd   = vecs[i].rd;
    order_rs1  = vecs[i].rs1;
    order_rs2  = vecs[i].rs2;
    order_imm  = vecs[i].imm;
  endtask

  task automatic expect_vec(input int i);
    exp_q.push_back('{err: vecs[i].err, inst: vecs[i].inst});
    if (vecs[i].err && exp_err_cnt != '1) exp_err_cnt = exp_err_cnt + 1'b1;
  endtask

  // Present one order and wait (bounded) for it to be accepted; returns at edge + 1.
  task automatic send_vec(input int i);
    int waited;
    waited = 0;
    drive_vec(i);
    in_valid = 1'b1;
    @(negedge clk_in);
    while (!in_ready && waited < 32) begin
      @(negedge clk_in);
      waited++;
    end
    if (in_ready) expect_vec(i);
    else check({vecs[i].name, "_accept_timeout"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk_in);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 64) begin
      @(posedge clk_in);
      #1;
      waited++;
    end
    check("drain_queue_empty", exp_q.size(), 32'd0);
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{"addi_neg1", `ADDI,  32'd1,  32'd0,  32'd0,  32'hFFFFFFFF, 32'hFFF00093, 1'b0};
    vecs[1]  = '{"lui",       `LUI,   32'd5,  32'd0,  32'd0,  32'h12345000, 32'h123452B7, 1'b0};
    vecs[2]  = '{"beq_back",  `BEQ,   32'd0,  32'd1,  32'd2,  32'hFFFFFFFC, 32'hFE208EE3, 1'b0};
    vecs[3]  = '{"sub",       `SUB,   32'd3,  32'd4,  32'd5,  32'd0,        32'h405201B3, 1'b0};
    vecs[4]  = '{"sw_rd_drop",`SW,    32'd7,  32'd2,  32'd8,  32'd12,       32'h00812623, 1'b0};
    vecs[5]  = '{"jal",       `JAL,   32'd1,  32'd0,  32'd0,  32'd8,        32'h008000EF, 1'b0};
    vecs[6]  = '{"srai",      `SRAI,  32'd6,  32'd7,  32'd0,  32'd3,        32'h4033D313, 1'b0};
    vecs[7]  = '{"lw_neg",    `LW,    32'd10, 32'd11, 32'd0,  32'hFFFFFFFC, 32'hFFC5A503, 1'b0};
    vecs[8]  = '{"auipc",     `AUIPC, 32'd2,  32'd0,  32'd0,  32'hFFFFF000, 32'hFFFFF117, 1'b0};
    vecs[9]  = '{"bne_fwd",   `BNE,   32'd0,  32'd3,  32'd4,  32'd16,       32'h00419863, 1'b0};
    vecs[10] = '{"jalr",      `JALR,  32'd0,  32'd1,  32'd0,  32'd0,        32'h00008067, 1'b0};
    vecs[11] = '{"slli_31",   `SLLI,  32'd1,  32'd1,  32'd0,  32'd31,       32'h01F09093, 1'b0};
    vecs[12] = '{"unknown",   6'd63,  32'd1,  32'd1,  32'd1,  32'd1,        32'h00000000, 1'b1};
    vecs[13] = '{"addi_800",  `ADDI,  32'd1,  32'd0,  32'd0,  32'h800,
                 RC ? 32'h0 : 32'h80000093, RC};
    vecs[14] = '{"or_rd_hi",  `OR,    32'h29, 32'd10, 32'd11, 32'd0,
                 RC ? 32'h0 : 32'h00B564B3, RC};
    vecs[15] = '{"beq_odd",   `BEQ,   32'd0,  32'd0,  32'd0,  32'd3,
                 RC ? 32'h0 : 32'h00000163, RC};
    vecs[16] = '{"slli_32",   `SLLI,  32'd0,  32'd0,  32'd0,  32'd32,
                 RC ? 32'h0 : 32'h00001013, RC};

    // Reset state.
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Table of orders, consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      send_vec(i);
      check({vecs[i].name, "_valid_next_cycle"}, {31'd0, out_valid}, 32'd1);
      check({vecs[i].name, "_err_cnt"}, {16'd0, err_cnt}, {16'd0, exp_err_cnt});
    end
    drain();

    // Back-pressure: two fill the FIFO, the third waits, then all drain in order.
    out_ready = 1'b0;
    send_vec(0);
    send_vec(1);
    check("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid_full", {31'd0, out_valid}, 32'd1);
    drive_vec(5);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk_in);
      check("bp_third_held", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk_in);
    #1;
    out_ready = 1'b1;
    @(negedge clk_in);
    check("bp_still_full_at_pop", {31'd0, in_ready}, 32'd0);
    @(negedge clk_in);
    if (in_ready) expect_vec(5);
    else check("bp_third_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk_in);
    #1;
    in_valid = 1'b0;
    check("bp_pushpop_valid", {31'd0, out_valid}, 32'd1);
    check("bp_pushpop_ready", {31'd0, in_ready}, 32'd1);
    drain();

    // Mid-cycle reset with the FIFO full discards everything at once.
    out_ready = 1'b0;
    send_vec(3);
    send_vec(12);
    check("mr_full", {31'd0, in_ready}, 32'd0);
    @(negedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    check("mr_out_valid", {31'd0, out_valid}, 32'd0);
    check("mr_in_ready", {31'd0, in_ready}, 32'd1);
    check("mr_out_inst", out_inst, 32'd0);
    check("mr_err_cnt", {16'd0, err_cnt}, 32'd0);
    exp_q.delete();
    exp_err_cnt = '0;
    #10;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    check("mr_no_stale", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    send_vec(6);
    drain();

    // Error counter saturation.
    for (int i = 0; i < 65534; i++) send_vec(12);
    check("sat_pre", {16'd0, err_cnt}, 32'h0000FFFE);
    repeat (3) send_vec(12);
    check("sat_hold", {16'd0, err_cnt}, 32'h0000FFFF);
    check("sat_model", {16'd0, err_cnt}, {16'd0, exp_err_cnt});
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
